// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, zero-register constant and trace record type
package cpu_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int PCW_DEF = 32;

  // Architectural zero register index; writes to it are dropped, reads return 0
  localparam int REG_ZERO = 0;

  // One committed-write record, shared by all trace emitters (GRF, DM)
  typedef struct packed {
    logic [PCW_DEF-1:0] pc;
    logic [AW_DEF-1:0]  addr;
    logic [DW_DEF-1:0]  data;
  } trace_rec_t;

endpackage

// File: rtl/grf_read_port.sv
// rtl/grf_read_port.sv - one GRF read port with zero-register check and writeback bypass
module grf_read_port
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_byp_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [DW-1:0] i_regs [2**AW],
  output logic [DW-1:0] o_data
);

  // Zero register wins, then the same-cycle writeback, then the stored value
  always_comb begin
    o_data = i_regs[i_addr];
    if (i_addr == AW'(REG_ZERO)) begin
      o_data = '0;
    end else if (i_byp_en && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
  end

endmodule

// File: rtl/grf_wb.sv
// rtl/grf_wb.sv - general-purpose register file with decode bypass and write trace
module grf_wb
  import cpu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int PCW = PCW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  a1,
  input  logic [AW-1:0]  a2,
  output logic [DW-1:0]  rd1,
  output logic [DW-1:0]  rd2,
  input  logic           we,
  input  logic [AW-1:0]  a3,
  input  logic [DW-1:0]  wd,
  input  logic [PCW-1:0] wpc,
  output logic           tr_valid,
  output logic [PCW-1:0] tr_pc,
  output logic [AW-1:0]  tr_addr,
  output logic [DW-1:0]  tr_data
);

  logic [DW-1:0]  r_regs [2**AW];
  logic           r_tr_valid;
  logic [PCW-1:0] r_tr_pc;
  logic [AW-1:0]  r_tr_addr;
  logic [DW-1:0]  r_tr_data;

  logic w_commit;
  logic w_byp_en;

  // A write only commits when enabled and not aimed at the zero register
  assign w_commit = we && (a3 != AW'(REG_ZERO));
  // Bypass is held off during reset so both ports read 0 while it is asserted
  assign w_byp_en = w_commit && !reset;

  // Register array: async clear, then one write per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[a3] <= wd;
    end
  end

  // Trace record: pulse valid for each committed write, payload holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tr_valid <= 1'b0;
      r_tr_pc    <= '0;
      r_tr_addr  <= '0;
      r_tr_data  <= '0;
    end else begin
      r_tr_valid <= w_commit;
      if (w_commit) begin
        r_tr_pc   <= wpc;
        r_tr_addr <= a3;
        r_tr_data <= wd;
      end
    end
  end

  grf_read_port #(.DW(DW), .AW(AW)) u_rp1 (
    .i_addr    (a1),
    .i_byp_en  (w_byp_en),
    .i_wr_addr (a3),
    .i_wr_data (wd),
    .i_regs    (r_regs),
    .o_data    (rd1)
  );

  grf_read_port #(.DW(DW), .AW(AW)) u_rp2 (
    .i_addr    (a2),
    .i_byp_en  (w_byp_en),
    .i_wr_addr (a3),
    .i_wr_data (wd),
    .i_regs    (r_regs),
    .o_data    (rd2)
  );

  assign tr_valid = r_tr_valid;
  assign tr_pc    = r_tr_pc;
  assign tr_addr  = r_tr_addr;
  assign tr_data  = r_tr_data;

  // An unknown write enable has no meaningful hardware behaviour
  a_we_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(we));

endmodule

// File: tb/tb_grf_wb.sv
// tb/tb_grf_wb.sv - directed self-checking bench for grf_wb
module tb_grf_wb;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2, a3;
  logic [31:0] rd1, rd2, wd, wpc;
  logic        we;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [4:0]  tr_addr;
  logic [31:0] tr_data;

  int tests;
  int fails;

  grf_wb dut (
    .clk      (clk),
    .reset    (reset),
    .a1       (a1),
    .a2       (a2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .a3       (a3),
    .wd       (wd),
    .wpc      (wpc),
    .tr_valid (tr_valid),
    .tr_pc    (tr_pc),
    .tr_addr  (tr_addr),
    .tr_data  (tr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // state while held in reset from power-up
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL por_tr_valid got %0h want 0", tr_valid); end
    tests++; if (tr_pc !== 32'h0 || tr_addr !== 5'h0 || tr_data !== 32'h0) begin fails++; $display("FAIL por_tr_payload got %h/%h/%h want 0/0/0", tr_pc, tr_addr, tr_data); end
    reset = 1'b0;
    tick();
    we = 1'b1; a3 = 5'd5; wd = 32'h1234; wpc = 32'h100;
    tick();
    we = 1'b0; a1 = 5'd5;
    #1;
    tests++; if (rd1 !== 32'h1234) begin fails++; $display("FAIL pre_reset_rd1 got %h want 00001234", rd1); end
    #1;
    reset = 1'b1;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL async_reset_rd1 got %h want 00000000", rd1); end
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL async_reset_tr_valid got %0h want 0", tr_valid); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    we = 1'b1; a3 = 5'd8; wd = 32'hDEADBEEF; wpc = 32'h3000; a2 = 5'd8;
    #1;
    tests++; if (rd2 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_bypass_rd2 got %h want deadbeef", rd2); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rd2 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rd2 got %h want deadbeef", rd2); end
    tests++; if (tr_valid !== 1'b1) begin fails++; $display("FAIL basic_tr_valid got %0h want 1", tr_valid); end
    tests++; if (tr_pc !== 32'h3000) begin fails++; $display("FAIL basic_tr_pc got %h want 00003000", tr_pc); end
    tests++; if (tr_addr !== 5'd8) begin fails++; $display("FAIL basic_tr_addr got %0d want 8", tr_addr); end
    tests++; if (tr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_tr_data got %h want deadbeef", tr_data); end
    tick();
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL basic_tr_drop got %0h want 0", tr_valid); end
    tests++; if (tr_addr !== 5'd8 || tr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_tr_hold got %0d/%h want 8/deadbeef", tr_addr, tr_data); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; a3 = 5'd0; wd = 32'hFFFFFFFF; wpc = 32'h4000; a1 = 5'd0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_same_cycle got %h want 00000000", rd1); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_after got %h want 00000000", rd1); end
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL zero_no_trace got %0h want 0", tr_valid); end
    tests++; if (tr_pc !== 32'h3000) begin fails++; $display("FAIL zero_tr_pc_hold got %h want 00003000", tr_pc); end
  endtask

  task automatic test_bypass();
    we = 1'b1; a3 = 5'd3; wd = 32'h11; wpc = 32'h5000;
    tick();
    we = 1'b0; a1 = 5'd3; a2 = 5'd3;
    #1;
    tests++; if (rd1 !== 32'h11) begin fails++; $display("FAIL byp_stored got %h want 00000011", rd1); end
    we = 1'b1; wd = 32'h22; wpc = 32'h5004;
    #1;
    tests++; if (rd1 !== 32'h22) begin fails++; $display("FAIL byp_rd1 got %h want 00000022", rd1); end
    tests++; if (rd2 !== 32'h22) begin fails++; $display("FAIL byp_rd2 got %h want 00000022", rd2); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h22) begin fails++; $display("FAIL byp_committed got %h want 00000022", rd1); end
    // a write elsewhere must not disturb either port
    we = 1'b1; a3 = 5'd4; wd = 32'h99;
    #1;
    tests++; if (rd1 !== 32'h22 || rd2 !== 32'h22) begin fails++; $display("FAIL byp_other_addr got %h/%h want 22/22", rd1, rd2); end
    we = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    we = 1'b1; a3 = 5'd1; wd = 32'hA1A1A1A1; wpc = 32'h6000;
    tick();
    a3 = 5'd2; wd = 32'hB2B2B2B2; wpc = 32'h6004;
    #1;
    tests++; if (tr_valid !== 1'b1 || tr_addr !== 5'd1) begin fails++; $display("FAIL b2b_first got v%0h a%0d want v1 a1", tr_valid, tr_addr); end
    tick();
    a3 = 5'd31; wd = 32'hC3C3C3C3; wpc = 32'h6008;
    #1;
    tests++; if (tr_valid !== 1'b1 || tr_addr !== 5'd2 || tr_pc !== 32'h6004) begin fails++; $display("FAIL b2b_second got v%0h a%0d pc%h want v1 a2 pc00006004", tr_valid, tr_addr, tr_pc); end
    tick();
    we = 1'b0;
    #1;
    tests++; if (tr_valid !== 1'b1 || tr_addr !== 5'd31 || tr_data !== 32'hC3C3C3C3) begin fails++; $display("FAIL b2b_third got v%0h a%0d d%h want v1 a31 dc3c3c3c3", tr_valid, tr_addr, tr_data); end
    tick();
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got %0h want 0", tr_valid); end
    a1 = 5'd1; a2 = 5'd2;
    #1;
    tests++; if (rd1 !== 32'hA1A1A1A1 || rd2 !== 32'hB2B2B2B2) begin fails++; $display("FAIL b2b_read12 got %h/%h want a1a1a1a1/b2b2b2b2", rd1, rd2); end
    a1 = 5'd31;
    #1;
    tests++; if (rd1 !== 32'hC3C3C3C3) begin fails++; $display("FAIL b2b_read31 got %h want c3c3c3c3", rd1); end
  endtask

  task automatic test_reset_on_write();
    a1 = 5'd9;
    @(negedge clk);
    we = 1'b1; a3 = 5'd9; wd = 32'h55; wpc = 32'h7000;
    reset = 1'b1;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL rstw_bypass_held got %h want 00000000", rd1); end
    tick();
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL rstw_tr_in_reset got %0h want 0", tr_valid); end
    we = 1'b0;
    reset = 1'b0;
    tick();
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL rstw_reg9 got %h want 00000000", rd1); end
    tests++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL rstw_no_trace got %0h want 0", tr_valid); end
    // first write after release behaves normally
    we = 1'b1; a3 = 5'd9; wd = 32'h66; wpc = 32'h7004;
    tick();
    we = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h66 || tr_valid !== 1'b1 || tr_addr !== 5'd9) begin fails++; $display("FAIL rstw_after got rd%h v%0h a%0d want rd66 v1 a9", rd1, tr_valid, tr_addr); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0; wpc = '0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_reset_on_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- General-purpose register file for the pipelined MIPS core.
- Consumes the 5-bit write-register address chosen by the rt/rd destination select in the writeback path, together with the writeback data and write enable.
- Serves the two decode-stage read ports, with internal write-to-read bypass so decode sees a same-cycle writeback.
- Emits a registered one-cycle write-trace record per committed write for the simulation checker.

Parameters:
- DW, 32, data width of each register and of rd1/rd2/wd.
- AW, 5, register address width; register count is 2**AW.
- PCW, 32, width of the PC carried with each write for trace.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- a1  input  AW  read port 1 address (rs)
- a2  input  AW  read port 2 address (rt)
- rd1  output  DW  read port 1 data, combinational
- rd2  output  DW  read port 2 data, combinational
- we  input  1  writeback write enable
- a3  input  AW  writeback destination register (output of the rt/rd select)
- wd  input  DW  writeback data
- wpc  input  PCW  PC of the instruction being written back
- tr_valid  output  1  trace record valid, one-cycle pulse
- tr_pc  output  PCW  PC of the traced write
- tr_addr  output  AW  register written
- tr_data  output  DW  value written

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset:
  - All registers clear to 0 immediately on reset assertion, without waiting for clk.
  - tr_valid, tr_pc, tr_addr and tr_data clear to 0.
  - rd1 and rd2 read 0 while reset is held.
- Write:
  - On a clk rising edge with we=1 and a3!=0, reg[a3] <= wd.
  - A write to register 0 is discarded. reg[0] reads 0 at all times.
  - we=0 leaves all state unchanged.
- Read: rdN = 0 if aN==0; else wd if (we && a3==aN); else reg[aN].
  - The bypass takes effect in the same cycle as the write, so there is zero-cycle latency from writeback to decode.
  - The bypass applies independently to both ports. If a1==a2==a3, both ports return wd.
  - The bypass is inhibited for a3==0.
- Trace:
  - On each edge that commits a write (we=1, a3!=0), the next cycle has tr_valid=1, with tr_pc=wpc, tr_addr=a3 and tr_data=wd as sampled at that edge.
  - On all other edges tr_valid <= 0. tr_pc, tr_addr and tr_data hold their last values.
  - Back-to-back writes produce back-to-back pulses, so tr_valid stays high continuously.
- Reset mid-operation:
  - Reset asserted during the write edge: reset wins. The register stays 0 and no trace pulse is produced.
  - After reset deasserts, the first edge behaves normally.
- X handling: we=X is treated as an error condition. A simulation assertion fires; there are no synthesis semantics for it.
- Widths: no arithmetic. Addresses are compared at the full AW width.

Decomposition:
- Shared package cpu_pkg holds:
  - DW, AW and PCW defaults.
  - The REG_ZERO constant (0).
  - A trace record typedef {pc, addr, data}, shared with the other trace emitters (DM write trace).
- One sub-module is natural: grf_read_port, holding the zero check, bypass compare and array read for one port. It is instantiated twice.
- The register array and trace register stay in grf_wb.

Test Plan:
- Reset: assert reset mid-cycle after writing reg[5]=0x1234 -> rd1 with a1=5 is 0 immediately, before any edge; tr_valid=0.
- Basic write/read: we=1, a3=8, wd=0xDEADBEEF, wpc=0x3000 at edge N -> from edge N, rd2 with a2=8 is 0xDEADBEEF; at edge N+1, tr_valid=1, tr_pc=0x3000, tr_addr=8, tr_data=0xDEADBEEF; at edge N+2, tr_valid=0.
- Zero register: we=1, a3=0, wd=0xFFFFFFFF -> rd1 with a1=0 is 0 in that cycle and after; no tr_valid pulse.
- Bypass: reg[3]=0x11; in one cycle drive a1=a2=a3=3, we=1, wd=0x22 -> rd1=rd2=0x22 before the edge; after the edge, with we=0, rd1=0x22.
- Back-to-back writes: writes to reg[1], reg[2] and reg[31] on consecutive edges -> tr_valid high for three cycles with addrs 1, 2, 31 in order; then all three registers read back correctly.
- Reset on write edge: assert reset coincident with a write of 0x55 to reg[9] -> after release, reg[9] reads 0 and no trace pulse occurs.
